mic1_next_addr: RTL and testbench

- Microsequencer stage directly downstream of the ULA. Latches the ULA N/Z outputs into the MIC-1 N/Z flip-flops and computes the next microprogram counter (MPC).
- Inputs: MIR fields NEXT_ADDRESS, JMPC, JAMN, JAMZ, plus MBR.
- Each microcycle takes two clocks: EXEC (sample ULA flags and MIR fields), then ADDR (update MPC).
- A stall input holds EXEC while memory is busy.

---
 rtl/mic1_pkg.sv | 12 +
 rtl/mic1_mpc_calc.sv | 28 ++
 rtl/mic1_next_addr.sv | 118 +++++++++++
 tb/tb_mic1_next_addr.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mic1_pkg.sv
// Shared widths, sequencer state codes and reset constants for the MIC-1 microsequencer.
package mic1_pkg;

    localparam int unsigned MIC1_ADDR_W = 9;
    localparam int unsigned MIC1_MBR_W  = 8;

    localparam logic ST_EXEC = 1'b0;
    localparam logic ST_ADDR = 1'b1;

    localparam logic [MIC1_ADDR_W-1:0] MPC_RESET = 9'h000;

endpackage

// File: rtl/mic1_mpc_calc.sv
// Next-MPC formation: MBR ORed into the low bits, N/Z jams ORed into the top bit.
module mic1_mpc_calc
    import mic1_pkg::*;
#(
    parameter int unsigned ADDR_W = MIC1_ADDR_W,
    parameter int unsigned MBR_W  = MIC1_MBR_W
) (
    input  logic [ADDR_W-1:0] na,
    input  logic              jmpc,
    input  logic              jamn,
    input  logic              jamz,
    input  logic [MBR_W-1:0]  mbr,
    input  logic              n,
    input  logic              z,
    output logic [ADDR_W-1:0] next_mpc
);

    logic [MBR_W-1:0] low;
    logic             high;

    // Pure OR: no carry out of the low field, so 0x1FF stays reachable.
    always_comb begin
        low      = na[MBR_W-1:0] | (jmpc ? mbr : '0);
        high     = na[ADDR_W-1] | (jamn & n) | (jamz & z);
        next_mpc = {high, low};
    end

endmodule

// File: rtl/mic1_next_addr.sv
// Two-phase MIC-1 microsequencer: EXEC latches ULA flags and MIR fields, ADDR updates MPC.
module mic1_next_addr
    import mic1_pkg::*;
#(
    parameter int unsigned ADDR_W = MIC1_ADDR_W,
    parameter int unsigned MBR_W  = MIC1_MBR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              n_in,
    input  logic              z_in,
    input  logic [ADDR_W-1:0] next_address,
    input  logic              jmpc,
    input  logic              jamn,
    input  logic              jamz,
    input  logic [MBR_W-1:0]  mbr,
    input  logic              stall,
    output logic [ADDR_W-1:0] mpc,
    output logic              n_flag,
    output logic              z_flag,
    output logic              phase,
    output logic              mpc_update
);

    if (ADDR_W != MBR_W + 1) begin : g_bad_width
        $error("mic1_next_addr: ADDR_W must equal MBR_W + 1");
    end

    logic              state_q, state_d;
    logic [ADDR_W-1:0] mpc_q, mpc_d;
    logic [ADDR_W-1:0] na_q, na_d;
    logic [MBR_W-1:0]  mbr_q, mbr_d;
    logic              n_q, n_d, z_q, z_d;
    logic              jmpc_q, jmpc_d, jamn_q, jamn_d, jamz_q, jamz_d;
    logic              upd_q, upd_d;
    logic [ADDR_W-1:0] next_mpc;
    logic              capture;

    assign capture = (state_q == ST_EXEC) && !stall;

    mic1_mpc_calc #(
        .ADDR_W (ADDR_W),
        .MBR_W  (MBR_W)
    ) u_mpc_calc (
        .na       (na_q),
        .jmpc     (jmpc_q),
        .jamn     (jamn_q),
        .jamz     (jamz_q),
        .mbr      (mbr_q),
        .n        (n_q),
        .z        (z_q),
        .next_mpc (next_mpc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EXEC;
            mpc_q   <= ADDR_W'(MPC_RESET);
            na_q    <= '0;
            mbr_q   <= '0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            jmpc_q  <= 1'b0;
            jamn_q  <= 1'b0;
            jamz_q  <= 1'b0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mpc_q   <= mpc_d;
            na_q    <= na_d;
            mbr_q   <= mbr_d;
            n_q     <= n_d;
            z_q     <= z_d;
            jmpc_q  <= jmpc_d;
            jamn_q  <= jamn_d;
            jamz_q  <= jamz_d;
            upd_q   <= upd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EXEC: if (!stall) state_d = ST_ADDR;
            ST_ADDR: state_d = ST_EXEC;
            default: state_d = ST_EXEC;
        endcase
    end

    always_comb begin
        na_d   = na_q;
        mbr_d  = mbr_q;
        n_d    = n_q;
        z_d    = z_q;
        jmpc_d = jmpc_q;
        jamn_d = jamn_q;
        jamz_d = jamz_q;
        if (capture) begin
            na_d   = next_address;
            mbr_d  = mbr;
            n_d    = n_in;
            z_d    = z_in;
            jmpc_d = jmpc;
            jamn_d = jamn;
            jamz_d = jamz;
        end
        // Stall is ignored in ADDR: MPC always advances and pulses the update strobe.
        mpc_d = (state_q == ST_ADDR) ? next_mpc : mpc_q;
        upd_d = (state_q == ST_ADDR);
    end

    assign mpc        = mpc_q;
    assign n_flag     = n_q;
    assign z_flag     = z_q;
    assign phase      = state_q;
    assign mpc_update = upd_q;

endmodule

// File: tb/tb_mic1_next_addr.sv
// Directed and randomized bench for mic1_next_addr against a per-edge behavioural model.
module tb_mic1_next_addr;
    import mic1_pkg::*;

    localparam int unsigned AW = MIC1_ADDR_W;
    localparam int unsigned MW = MIC1_MBR_W;

    logic          clk = 1'b0;
    logic          reset;
    logic          n_in, z_in, jmpc, jamn, jamz, stall;
    logic [AW-1:0] next_address;
    logic [MW-1:0] mbr;
    logic [AW-1:0] mpc;
    logic          n_flag, z_flag, phase, mpc_update;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Reference state
    int unsigned m_mpc;
    bit          m_n, m_z, m_phase, m_upd;
    int unsigned c_na, c_mbr;
    bit          c_jmpc, c_jamn, c_jamz;

    always #5 clk = ~clk;

    mic1_next_addr dut (
        .clk          (clk),
        .reset        (reset),
        .n_in         (n_in),
        .z_in         (z_in),
        .next_address (next_address),
        .jmpc         (jmpc),
        .jamn         (jamn),
        .jamz         (jamz),
        .mbr          (mbr),
        .stall        (stall),
        .mpc          (mpc),
        .n_flag       (n_flag),
        .z_flag       (z_flag),
        .phase        (phase),
        .mpc_update   (mpc_update)
    );

    // Address = 256 * top bit + low byte, each built from the MIR rules with plain arithmetic.
    function automatic int unsigned ref_mpc(input int unsigned na, input int unsigned mb,
                                            input bit jc, input bit jn, input bit jz,
                                            input bit n, input bit z);
        int unsigned low, high;
        low  = na % (2 ** MW);
        if (jc) low = low | mb;
        high = na / (2 ** MW);
        if (jn && n) high = 1;
        if (jz && z) high = 1;
        return high * (2 ** MW) + low;
    endfunction

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        if (reset) begin
            m_mpc = 0; m_n = 0; m_z = 0; m_phase = 0; m_upd = 0;
            c_na = 0; c_mbr = 0; c_jmpc = 0; c_jamn = 0; c_jamz = 0;
        end else if (m_phase == 0) begin
            m_upd = 0;
            if (!stall) begin
                m_n = n_in; m_z = z_in;
                c_na = next_address; c_mbr = mbr;
                c_jmpc = jmpc; c_jamn = jamn; c_jamz = jamz;
                m_phase = 1;
            end
        end else begin
            m_mpc   = ref_mpc(c_na, c_mbr, c_jmpc, c_jamn, c_jamz, m_n, m_z);
            m_upd   = 1;
            m_phase = 0;
        end
        @(posedge clk);
        #1;
        check("mpc", mpc, m_mpc);
        check("n_flag", n_flag, m_n);
        check("z_flag", z_flag, m_z);
        check("phase", phase, m_phase);
        check("mpc_update", mpc_update, m_upd);
    endtask

    task automatic set_mir(input int unsigned na, input bit jc, input bit jn, input bit jz,
                           input int unsigned mb, input bit n, input bit z);
        next_address = AW'(na);
        jmpc = jc; jamn = jn; jamz = jz;
        mbr  = MW'(mb);
        n_in = n; z_in = z;
    endtask

    initial begin
        int unsigned a, b, r;
        reset = 1'b1; stall = 1'b0;
        set_mir(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        // Plain jump
        set_mir('h012, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("tp1_mpc", mpc, 'h012);
        check("tp1_upd", mpc_update, 1);

        // JAMZ taken, then not taken
        set_mir('h040, 0, 0, 1, 0, 0, 1);
        tick();
        check("tp2_upd_low", mpc_update, 0);
        tick();
        check("tp2_zflag", z_flag, 1);
        check("tp2_mpc", mpc, 'h140);
        set_mir('h040, 0, 0, 1, 0, 0, 0);
        tick();
        tick();
        check("tp2b_mpc", mpc, 'h040);

        // JMPC, then JMPC with JAMN
        set_mir('h000, 1, 0, 0, 'hA7, 0, 0);
        tick();
        tick();
        check("tp3_mpc", mpc, 'h0A7);
        set_mir('h100, 1, 1, 0, 'h3C, 1, 0);
        tick();
        tick();
        check("tp3b_mpc", mpc, 'h13C);

        // Stall holds EXEC
        set_mir('h055, 0, 0, 0, 0, 1, 1);
        stall = 1'b1;
        repeat (3) tick();
        check("tp4_hold_mpc", mpc, 'h13C);
        check("tp4_hold_n", n_flag, 1);
        check("tp4_hold_z", z_flag, 0);
        stall = 1'b0;
        set_mir('h055, 0, 0, 0, 0, 0, 0);
        tick();
        check("tp4_not_yet", mpc, 'h13C);
        tick();
        check("tp4_mpc", mpc, 'h055);

        // Reset during ADDR
        set_mir('h1FF, 1, 1, 1, 'hFF, 1, 1);
        tick();
        check("tp5_in_addr", phase, 1);
        reset = 1'b1;
        tick();
        check("tp5_mpc", mpc, 0);
        check("tp5_upd", mpc_update, 0);
        reset = 1'b0;

        // ULA chain: B - A, then a zero result
        a = 1; b = 2; r = b - a;
        set_mir('h020, 0, 1, 0, 0, r[31], r == 0);
        tick();
        tick();
        check("tp6_mpc", mpc, 'h020);
        r = 0;
        set_mir('h020, 0, 0, 1, 0, r[31], r == 0);
        tick();
        tick();
        check("tp6b_mpc", mpc, 'h120);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            set_mir($urandom_range(0, 2 ** AW - 1), $urandom_range(0, 1), $urandom_range(0, 1),
                    $urandom_range(0, 1), $urandom_range(0, 2 ** MW - 1),
                    $urandom_range(0, 1), $urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0);
            reset = ($urandom_range(0, 60) == 0);
            tick();
        end
        reset = 1'b0;
        stall = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
